// File: rtl/timer_bus_arbiter.sv
// Round-robin arbiter sharing the timer peripheral register port between N_REQ bus masters.
// One outstanding access at a time (IDLE -> ACCESS -> RESP), with an optional bus timeout.
module timer_bus_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_rw,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_done,
  output logic                      req_error,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [N_REQ-1:0]          grant,
  output logic                      p_cs,
  output logic [ADDR_W-1:0]         p_addr,
  output logic                      p_rw,
  output logic [DATA_W-1:0]         p_wdata,
  input  logic [DATA_W-1:0]         p_rdata,
  input  logic                      p_error,
  input  logic                      p_ready
);

  localparam int PTR_W = (N_REQ < 2) ? 1 : $clog2(N_REQ);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    req_done_q, req_done_d;
  logic                req_error_q, req_error_d;
  logic [DATA_W-1:0]   req_rdata_q, req_rdata_d;
  logic                p_cs_q, p_cs_d;
  logic [ADDR_W-1:0]   p_addr_q, p_addr_d;
  logic                p_rw_q, p_rw_d;
  logic [DATA_W-1:0]   p_wdata_q, p_wdata_d;

  logic                found;
  logic [PTR_W-1:0]    pick;
  logic [PTR_W:0]      idx;
  logic                sel_rw;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Search starts at the rr pointer and wraps, so the last winner has lowest priority.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    found     = 1'b0;
    pick      = '0;
    idx       = '0;
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(N_REQ)) idx = idx - (PTR_W+1)'(N_REQ);
      if (!found && req_valid[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[PTR_W-1:0];
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (pick == PTR_W'(j)) begin
        sel_rw    = req_rw[j];
        sel_addr  = req_addr[j*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    req_done_d  = '0;
    req_error_d = req_error_q;
    req_rdata_d = req_rdata_q;
    p_cs_d      = p_cs_q;
    p_addr_d    = p_addr_q;
    p_rw_d      = p_rw_q;
    p_wdata_d   = p_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d   = ST_ACCESS;
          grant_d   = N_REQ'(1) << pick;
          p_cs_d    = 1'b1;
          p_addr_d  = sel_addr;
          p_rw_d    = sel_rw;
          p_wdata_d = sel_wdata;
          ptr_d     = (pick == PTR_W'(N_REQ - 1)) ? '0 : pick + 1'b1;
          cnt_d     = '0;
        end
      end
      ST_ACCESS: begin
        if (p_ready) begin
          state_d     = ST_RESP;
          p_cs_d      = 1'b0;
          req_done_d  = grant_q;
          req_rdata_d = p_rw_q ? '0 : p_rdata;
          req_error_d = p_error;
          cnt_d       = '0;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d     = ST_RESP;
          p_cs_d      = 1'b0;
          req_done_d  = grant_q;
          req_rdata_d = '0;
          req_error_d = 1'b1;
          cnt_d       = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its inputs.
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      req_done_q  <= '0;
      req_error_q <= 1'b0;
      req_rdata_q <= '0;
      p_cs_q      <= 1'b0;
      p_addr_q    <= '0;
      p_rw_q      <= 1'b0;
      p_wdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      req_done_q  <= req_done_d;
      req_error_q <= req_error_d;
      req_rdata_q <= req_rdata_d;
      p_cs_q      <= p_cs_d;
      p_addr_q    <= p_addr_d;
      p_rw_q      <= p_rw_d;
      p_wdata_q   <= p_wdata_d;
    end
  end

  assign req_done  = req_done_q;
  assign req_error = req_error_q;
  assign req_rdata = req_rdata_q;
  assign grant     = grant_q;
  assign p_cs      = p_cs_q;
  assign p_addr    = p_addr_q;
  assign p_rw      = p_rw_q;
  assign p_wdata   = p_wdata_q;

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Bench for timer_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (round-robin pick, response data/error rules, 3-cycle framing).
module tb_timer_bus_arbiter;

  localparam int N_REQ   = 2;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ-1:0]        req_rw = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr = '0;
  logic [N_REQ*DATA_W-1:0] req_wdata = '0;
  logic [N_REQ-1:0]        req_done;
  logic                    req_error;
  logic [DATA_W-1:0]       req_rdata;
  logic [N_REQ-1:0]        grant;
  logic                    p_cs;
  logic [ADDR_W-1:0]       p_addr;
  logic                    p_rw;
  logic [DATA_W-1:0]       p_wdata;
  logic [DATA_W-1:0]       p_rdata = '0;
  logic                    p_error = 1'b0;
  logic                    p_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Master-side request state and model state
  logic [N_REQ-1:0]  pend = '0;
  logic              m_rw    [N_REQ];
  logic [ADDR_W-1:0] m_addr  [N_REQ];
  logic [DATA_W-1:0] m_wdata [N_REQ];
  int                model_ptr = 0;
  logic [DATA_W-1:0] exp_rdata = '0;
  logic              exp_err = 1'b0;

  timer_bus_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_error(req_error), .req_rdata(req_rdata), .grant(grant),
    .p_cs(p_cs), .p_addr(p_addr), .p_rw(p_rw), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_error(p_error), .p_ready(p_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [N_REQ-1:0] mask, input int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (mask[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N_REQ; i++) begin
      req_valid[i] = pend[i];
      req_rw[i]    = m_rw[i];
      req_addr[i*ADDR_W +: ADDR_W]  = m_addr[i];
      req_wdata[i*DATA_W +: DATA_W] = m_wdata[i];
    end
  endtask

  // One arbitration slot starting in IDLE: predicts winner, checks ACCESS, RESP and the IDLE after.
  task automatic run_slot(input int delay, input logic [DATA_W-1:0] rd, input logic pe,
                          input logic early, output int w, output int dc);
    logic [N_REQ-1:0] oh;
    logic to;
    logic ready_now;
    logic fin;
    int k;
    drive_reqs();
    p_ready = 1'b0;
    w = model_pick(pend, model_ptr);
    if (w < 0) w = 0;
    model_ptr = (w + 1) % N_REQ;
    oh = N_REQ'(1) << w;
    tick();
    checks++; if (grant !== oh) begin failures++; $display("FAIL grant_access: got %b want %b", grant, oh); end
    checks++; if (p_addr !== m_addr[w]) begin failures++; $display("FAIL p_addr: got %h want %h", p_addr, m_addr[w]); end
    checks++; if (p_rw !== m_rw[w]) begin failures++; $display("FAIL p_rw: got %b want %b", p_rw, m_rw[w]); end
    checks++; if (p_wdata !== m_wdata[w]) begin failures++; $display("FAIL p_wdata: got %h want %h", p_wdata, m_wdata[w]); end
    checks++; if (req_done !== '0) begin failures++; $display("FAIL done_in_access: got %b want 0", req_done); end
    if (early) begin
      pend[w] = 1'b0;
      drive_reqs();
    end
    k = 0; to = 1'b0; fin = 1'b0;
    while (!fin) begin
      checks++; if (p_cs !== 1'b1) begin failures++; $display("FAIL p_cs_access: cycle %0d got %b want 1", k, p_cs); end
      ready_now = (k == delay);
      p_ready = ready_now;
      p_rdata = ready_now ? rd : DATA_W'($urandom);
      p_error = ready_now ? pe : 1'($urandom);
      tick();
      k++;
      p_ready = 1'b0;
      if (ready_now) fin = 1'b1;
      else if (k == TIMEOUT) begin to = 1'b1; fin = 1'b1; end
    end
    exp_rdata = (to || m_rw[w]) ? '0 : rd;
    exp_err   = to ? 1'b1 : pe;
    dc = cyc;
    checks++; if (req_done !== oh) begin failures++; $display("FAIL req_done: got %b want %b", req_done, oh); end
    checks++; if (req_error !== exp_err) begin failures++; $display("FAIL req_error: got %b want %b", req_error, exp_err); end
    checks++; if (req_rdata !== exp_rdata) begin failures++; $display("FAIL req_rdata: got %h want %h", req_rdata, exp_rdata); end
    checks++; if (p_cs !== 1'b0) begin failures++; $display("FAIL p_cs_resp: got %b want 0", p_cs); end
    checks++; if (grant !== oh) begin failures++; $display("FAIL grant_resp: got %b want %b", grant, oh); end
    pend[w] = 1'b0;
    drive_reqs();
    tick();
    checks++; if (req_done !== '0) begin failures++; $display("FAIL done_pulse: got %b want 0", req_done); end
    checks++; if (grant !== '0) begin failures++; $display("FAIL grant_idle: got %b want 0", grant); end
    checks++; if (req_rdata !== exp_rdata) begin failures++; $display("FAIL rdata_hold: got %h want %h", req_rdata, exp_rdata); end
    checks++; if (req_error !== exp_err) begin failures++; $display("FAIL error_hold: got %b want %b", req_error, exp_err); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    model_ptr = 0;
    checks++; if (grant !== '0) begin failures++; $display("FAIL rst_grant: got %b want 0", grant); end
    checks++; if (p_cs !== 1'b0) begin failures++; $display("FAIL rst_p_cs: got %b want 0", p_cs); end
    checks++; if (p_addr !== '0) begin failures++; $display("FAIL rst_p_addr: got %h want 0", p_addr); end
    checks++; if (p_rw !== 1'b0) begin failures++; $display("FAIL rst_p_rw: got %b want 0", p_rw); end
    checks++; if (p_wdata !== '0) begin failures++; $display("FAIL rst_p_wdata: got %h want 0", p_wdata); end
    checks++; if (req_done !== '0) begin failures++; $display("FAIL rst_req_done: got %b want 0", req_done); end
    checks++; if (req_error !== 1'b0) begin failures++; $display("FAIL rst_req_error: got %b want 0", req_error); end
    checks++; if (req_rdata !== '0) begin failures++; $display("FAIL rst_req_rdata: got %h want 0", req_rdata); end
  endtask

  task automatic test_round_robin();
    int w, dc, last_dc;
    last_dc = 0;
    pend = '1;
    for (int i = 0; i < N_REQ; i++) begin
      m_rw[i] = 1'b0; m_addr[i] = ADDR_W'(8'h40 + i); m_wdata[i] = DATA_W'($urandom);
    end
    for (int r = 0; r < 4; r++) begin
      run_slot(0, DATA_W'($urandom), 1'b0, 1'b0, w, dc);
      checks++; if (w != r % 2) begin failures++; $display("FAIL rr_order: slot %0d got %0d want %0d", r, w, r % 2); end
      if (r > 0) begin
        checks++; if (dc - last_dc != 3) begin failures++; $display("FAIL rr_spacing: got %0d want 3", dc - last_dc); end
      end
      last_dc = dc;
      pend[w] = 1'b1;
      m_wdata[w] = DATA_W'($urandom);
    end
  endtask

  task automatic test_write();
    int w, dc;
    pend = 2'b01;
    m_rw[0] = 1'b1; m_addr[0] = 8'h08; m_wdata[0] = 32'h5;
    run_slot(0, 32'hDEAD_BEEF, 1'b0, 1'b0, w, dc);
    checks++; if (req_rdata !== 32'h0) begin failures++; $display("FAIL write_rdata: got %h want 0", req_rdata); end
  endtask

  task automatic test_read();
    int w, dc;
    pend = 2'b10;
    m_rw[1] = 1'b0; m_addr[1] = 8'h00; m_wdata[1] = DATA_W'($urandom);
    run_slot(0, 32'h1234, 1'b0, 1'b0, w, dc);
    checks++; if (req_rdata !== 32'h1234) begin failures++; $display("FAIL read_rdata: got %h want 1234", req_rdata); end
  endtask

  task automatic test_timeout();
    int w, dc;
    pend = 2'b01;
    m_rw[0] = 1'b0; m_addr[0] = 8'h0C; m_wdata[0] = DATA_W'($urandom);
    run_slot(TIMEOUT + 100, 32'hFFFF_FFFF, 1'b0, 1'b0, w, dc);
    checks++; if (req_error !== 1'b1) begin failures++; $display("FAIL timeout_error: got %b want 1", req_error); end
    checks++; if (req_rdata !== 32'h0) begin failures++; $display("FAIL timeout_rdata: got %h want 0", req_rdata); end
  endtask

  task automatic test_periph_error();
    int w, dc;
    pend = 2'b10;
    m_rw[1] = 1'b0; m_addr[1] = 8'h84; m_wdata[1] = DATA_W'($urandom);
    run_slot(2, 32'h0000_00A5, 1'b1, 1'b0, w, dc);
    checks++; if (req_error !== 1'b1) begin failures++; $display("FAIL perr_error: got %b want 1", req_error); end
  endtask

  task automatic test_reset_mid_access();
    int w, dc;
    pend = 2'b01;
    m_rw[0] = 1'b0; m_addr[0] = 8'h10; m_wdata[0] = DATA_W'($urandom);
    drive_reqs();
    p_ready = 1'b0;
    tick();
    checks++; if (grant !== 2'b01) begin failures++; $display("FAIL rmid_grant: got %b want 01", grant); end
    checks++; if (p_cs !== 1'b1) begin failures++; $display("FAIL rmid_p_cs: got %b want 1", p_cs); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_ptr = 0;
    checks++; if (p_cs !== 1'b0) begin failures++; $display("FAIL rmid_after_p_cs: got %b want 0", p_cs); end
    checks++; if (grant !== '0) begin failures++; $display("FAIL rmid_after_grant: got %b want 0", grant); end
    checks++; if (req_done !== '0) begin failures++; $display("FAIL rmid_after_done: got %b want 0", req_done); end
    pend = 2'b11;
    m_rw[1] = 1'b0; m_addr[1] = 8'h20; m_wdata[1] = DATA_W'($urandom);
    run_slot(0, 32'hCAFE_0001, 1'b0, 1'b0, w, dc);
    checks++; if (grant !== '0 || w != 0) begin failures++; $display("FAIL rmid_winner: got %0d want 0", w); end
    run_slot(1, 32'hCAFE_0002, 1'b0, 1'b0, w, dc);
  endtask

  task automatic test_random();
    int w, dc, delay, sel;
    for (int s = 0; s < 300; s++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]    = 1'b1;
          m_rw[i]    = 1'($urandom);
          m_addr[i]  = ADDR_W'($urandom);
          m_wdata[i] = DATA_W'($urandom);
        end
      end
      if (pend == '0) begin
        drive_reqs();
        tick();
        checks++; if (p_cs !== 1'b0 || grant !== '0) begin failures++; $display("FAIL idle_stay: p_cs %b grant %b want 0 0", p_cs, grant); end
      end else begin
        sel = $urandom_range(0, 9);
        if (sel <= 5)      delay = $urandom_range(0, 2);
        else if (sel <= 7) delay = $urandom_range(3, TIMEOUT - 1);
        else if (sel == 8) delay = TIMEOUT - 1;
        else               delay = TIMEOUT + $urandom_range(0, 3);
        run_slot(delay, DATA_W'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), w, dc);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      m_rw[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0;
    end
    test_reset();
    test_round_robin();
    test_write();
    test_read();
    test_timeout();
    test_periph_error();
    test_reset_mid_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
